// File: rtl/draw_rect_if.sv
// Pixel bus between the 800x600 timing generator, the position requester and draw_rect.
// master: drives the *_in timing/RGB bus and the position request, observes the outputs.
// slave : draw_rect itself.
interface draw_rect_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        hblnk_in;
    logic        vsync_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;

    logic [10:0] xpos_in;
    logic [10:0] ypos_in;
    logic        pos_valid;
    logic        pos_ready;

    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
        output xpos_in, ypos_in, pos_valid,
        input  pos_ready,
        input  hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
        input  xpos_in, ypos_in, pos_valid,
        output pos_ready,
        output hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/draw_rect.sv
// draw_rect: overlays a solid (or outlined) rectangle on the pixel stream and re-emits the
// timing bus two cycles later. Position updates arrive over valid/ready and are applied
// only on the rising edge of vblnk_in so a frame never tears.
// Optional feature: define DRAW_RECT_BORDER_EN to draw only a BORDER-pixel outline.
module draw_rect #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 48,
    parameter logic [11:0] COLOR  = 12'hF00,
    parameter int unsigned X_INIT = 0,
    parameter int unsigned Y_INIT = 0,
    parameter int unsigned BORDER = 2
) (
    input logic        pclk,
    input logic        rst_n,
    draw_rect_if.slave bus
);

`ifdef DRAW_RECT_BORDER_EN
    localparam bit BorderEn = 1'b1;
`else
    localparam bit BorderEn = 1'b0;
`endif
    // An outline this thick covers the whole rectangle, so draw it solid.
    localparam bit BorderSolid = (2 * BORDER >= WIDTH) || (2 * BORDER >= HEIGHT);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        hblnk;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } tbus_t;

    typedef enum logic {StIdle, StPending} state_e;

    // Pipeline state
    tbus_t s1_d, s1_q;
    tbus_t s2_d, s2_q;
    logic  draw_s1_d, draw_s1_q;

    // Handshake state
    state_e      state_d, state_q;
    logic        pos_ready_d, pos_ready_q;
    logic [10:0] xa_d, xa_q;
    logic [10:0] ya_d, ya_q;
    logic [10:0] xp_d, xp_q;
    logic [10:0] yp_d, yp_q;
    logic        vblnk_prev_d, vblnk_prev_q;

    // Rectangle bounds at 12 bits so a rectangle past the frame edge clips instead of wrapping.
    logic [11:0] h12, v12;
    logic [11:0] x_lo, x_hi, y_lo, y_hi;
    logic        in_rect, rim;
    logic        vblnk_rise;

    // Stage 1 hit test and stage 2 compositing.
    always_comb begin
        h12  = {1'b0, bus.hcount_in};
        v12  = {1'b0, bus.vcount_in};
        x_lo = {1'b0, xa_q};
        y_lo = {1'b0, ya_q};
        x_hi = x_lo + 12'(WIDTH);
        y_hi = y_lo + 12'(HEIGHT);

        in_rect = (h12 >= x_lo) && (h12 < x_hi) && (v12 >= y_lo) && (v12 < y_hi);
        rim     = (h12 < x_lo + 12'(BORDER)) || (h12 >= x_hi - 12'(BORDER)) ||
                  (v12 < y_lo + 12'(BORDER)) || (v12 >= y_hi - 12'(BORDER));

        draw_s1_d = in_rect && (!BorderEn || BorderSolid || rim);

        s1_d.hcount = bus.hcount_in;
        s1_d.vcount = bus.vcount_in;
        s1_d.hsync  = bus.hsync_in;
        s1_d.hblnk  = bus.hblnk_in;
        s1_d.vsync  = bus.vsync_in;
        s1_d.vblnk  = bus.vblnk_in;
        s1_d.rgb    = bus.rgb_in;

        s2_d = s1_q;
        if (s1_q.hblnk || s1_q.vblnk) begin
            s2_d.rgb = 12'h000;
        end else if (draw_s1_q) begin
            s2_d.rgb = COLOR;
        end
    end

    // Next-state for the position handshake.
    always_comb begin
        vblnk_rise   = bus.vblnk_in && !vblnk_prev_q;
        vblnk_prev_d = bus.vblnk_in;
        state_d      = state_q;
        pos_ready_d  = pos_ready_q;
        xa_d         = xa_q;
        ya_d         = ya_q;
        xp_d         = xp_q;
        yp_d         = yp_q;
        unique case (state_q)
            StIdle: begin
                // A request accepted on the edge cycle itself waits for the next frame.
                if (bus.pos_valid) begin
                    xp_d        = bus.xpos_in;
                    yp_d        = bus.ypos_in;
                    state_d     = StPending;
                    pos_ready_d = 1'b0;
                end
            end
            StPending: begin
                if (vblnk_rise) begin
                    xa_d        = xp_q;
                    ya_d        = yp_q;
                    state_d     = StIdle;
                    pos_ready_d = 1'b1;
                end
            end
        endcase
    end

    // Two-stage pixel pipeline registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            draw_s1_q <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            draw_s1_q <= draw_s1_d;
        end
    end

    // Handshake FSM with registered pos_ready and active/pending positions.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pos_ready_q  <= 1'b1;
            xa_q         <= 11'(X_INIT);
            ya_q         <= 11'(Y_INIT);
            xp_q         <= '0;
            yp_q         <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_ready_q  <= pos_ready_d;
            xa_q         <= xa_d;
            ya_q         <= ya_d;
            xp_q         <= xp_d;
            yp_q         <= yp_d;
            vblnk_prev_q <= vblnk_prev_d;
        end
    end

    assign bus.pos_ready  = pos_ready_q;
    assign bus.hcount_out = s2_q.hcount;
    assign bus.vcount_out = s2_q.vcount;
    assign bus.hsync_out  = s2_q.hsync;
    assign bus.hblnk_out  = s2_q.hblnk;
    assign bus.vsync_out  = s2_q.vsync;
    assign bus.vblnk_out  = s2_q.vblnk;
    assign bus.rgb_out    = s2_q.rgb;

endmodule

// File: tb/tb_draw_rect.sv
// Self-checking bench for draw_rect: a compressed 1056x628 raster with random pixel colours,
// checked against a frame-level model of the rectangle overlay and position handshake.
`timescale 1ns/1ps
module tb_draw_rect;
    localparam int          W   = 64;
    localparam int          H   = 48;
    localparam int          B   = 2;
    localparam logic [11:0] COL = 12'hF00;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    draw_rect_if bus();

    draw_rect dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #12 pclk = ~pclk;

    typedef struct {
        int          h;
        int          v;
        bit          hs;
        bit          hb;
        bit          vs;
        bit          vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Model of the rectangle position and handshake
    int m_xa, m_ya, m_px, m_py;
    bit m_ready, m_prev_vb;

    // Requester: holds valid while req queue non-empty; stage queue released at a chosen line
    int  req_x[$], req_y[$];
    int  stage_x[$], stage_y[$];
    bit  rgb_fixed = 1'b0;
    int  frame_lines[$] = '{0, 1, 37, 38, 47, 48, 49, 199, 200, 201, 247, 248, 300,
                            589, 590, 591, 599, 600, 601, 602, 627};

    function automatic logic [11:0] model_rgb(int h, int v, logic [11:0] rgb, int xa, int ya);
        bit in_rect, rim_px;
        if (h >= 800 || v >= 600) return 12'h000;
        in_rect = (h >= xa) && (h < xa + W) && (v >= ya) && (v < ya + H);
`ifdef DRAW_RECT_BORDER_EN
        rim_px = (2 * B >= W) || (2 * B >= H) || (h - xa < B) || (xa + W - 1 - h < B) ||
                 (v - ya < B) || (ya + H - 1 - v < B);
`else
        rim_px = 1'b1;
`endif
        return (in_rect && rim_px) ? COL : rgb;
    endfunction

    task automatic reset_model();
        exp_t z;
        z = '{h: 0, v: 0, hs: 0, hb: 0, vs: 0, vb: 0, rgb: 12'h000};
        m_xa = 0; m_ya = 0; m_px = 0; m_py = 0;
        m_ready = 1'b1; m_prev_vb = 1'b0;
        exp_q.delete();
        exp_q.push_back(z);
        req_x.delete(); req_y.delete();
    endtask

    // Drive one pixel, advance the model, and compare the outputs due this cycle.
    task automatic drive_px(input int h, input int v, input logic [11:0] rgb);
        exp_t e;
        bit   hs, hb, vs, vb, accepted;
        hb = (h >= 800);
        hs = (h >= 840) && (h < 968);
        vb = (v >= 600);
        vs = (v >= 601) && (v < 605);
        bus.hcount_in = 11'(h);
        bus.vcount_in = 11'(v);
        bus.hsync_in  = hs;
        bus.hblnk_in  = hb;
        bus.vsync_in  = vs;
        bus.vblnk_in  = vb;
        bus.rgb_in    = rgb;
        bus.pos_valid = (req_x.size() > 0);
        if (req_x.size() > 0) begin
            bus.xpos_in = 11'(req_x[0]);
            bus.ypos_in = 11'(req_y[0]);
        end else begin
            bus.xpos_in = 11'($urandom);
            bus.ypos_in = 11'($urandom);
        end
        e = '{h: h, v: v, hs: hs, hb: hb, vs: vs, vb: vb,
              rgb: model_rgb(h, v, rgb, m_xa, m_ya)};
        exp_q.push_back(e);
        accepted = 1'b0;
        if (m_ready) begin
            if (req_x.size() > 0) begin
                m_px = req_x[0]; m_py = req_y[0]; m_ready = 1'b0; accepted = 1'b1;
            end
        end else if (vb && !m_prev_vb) begin
            m_xa = m_px; m_ya = m_py; m_ready = 1'b1;
        end
        m_prev_vb = vb;
        @(posedge pclk);
        #1;
        if (accepted) begin
            void'(req_x.pop_front());
            void'(req_y.pop_front());
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.hblnk_out, bus.vsync_out,
             bus.vblnk_out} !== {11'(e.h), 11'(e.v), e.hs, e.hb, e.vs, e.vb}) begin
            errors++;
            $display("FAIL timing: got h=%0d v=%0d hs%0b hb%0b vs%0b vb%0b want h=%0d v=%0d hs%0b hb%0b vs%0b vb%0b",
                     bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.hblnk_out,
                     bus.vsync_out, bus.vblnk_out, e.h, e.v, e.hs, e.hb, e.vs, e.vb);
        end
        checks++;
        if (bus.rgb_out !== e.rgb) begin
            errors++;
            $display("FAIL rgb at (%0d,%0d): got %h want %h", e.h, e.v, bus.rgb_out, e.rgb);
        end
        checks++;
        if (bus.pos_ready !== m_ready) begin
            errors++;
            $display("FAIL pos_ready after (%0d,%0d): got %b want %b", h, v, bus.pos_ready,
                     m_ready);
        end
    endtask

    function automatic logic [11:0] pick_rgb();
        return rgb_fixed ? 12'h0AB : 12'($urandom);
    endfunction

    task automatic run_line(input int v);
        for (int h = 0; h < 120; h++) drive_px(h, v, pick_rgb());
        for (int h = 760; h < 860; h++) drive_px(h, v, pick_rgb());
        for (int h = 1040; h < 1056; h++) drive_px(h, v, pick_rgb());
    endtask

    // Compressed frame; staged requests are presented starting at line req_line.
    task automatic run_frame(input int req_line);
        foreach (frame_lines[i]) begin
            if (frame_lines[i] == req_line) begin
                while (stage_x.size() > 0) begin
                    req_x.push_back(stage_x.pop_front());
                    req_y.push_back(stage_y.pop_front());
                end
            end
            run_line(frame_lines[i]);
        end
    endtask

    task automatic apply_reset();
        #1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.hcount_in = 11'($urandom); bus.vcount_in = 11'($urandom);
            bus.hsync_in = 1'($urandom); bus.hblnk_in = 1'($urandom);
            bus.vsync_in = 1'($urandom); bus.vblnk_in = 1'($urandom);
            bus.rgb_in = 12'($urandom); bus.pos_valid = 1'($urandom);
            bus.xpos_in = 11'($urandom); bus.ypos_in = 11'($urandom);
            @(posedge pclk);
            #1;
            checks++;
            if ({bus.hcount_out, bus.vcount_out, bus.hsync_out, bus.hblnk_out, bus.vsync_out,
                 bus.vblnk_out, bus.rgb_out} !== 38'h0) begin
                errors++;
                $display("FAIL reset outputs: got h=%0d v=%0d rgb=%h want all 0",
                         bus.hcount_out, bus.vcount_out, bus.rgb_out);
            end
            checks++;
            if (bus.pos_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset pos_ready: got %b want 1", bus.pos_ready);
            end
        end
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_reset();
        apply_reset();
        drive_px(0, 0, 12'h0AB);
        drive_px(1, 0, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(0,0): got %h want f00", bus.rgb_out);
        end
        drive_px(64, 0, 12'h0AB);
        drive_px(65, 0, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'h0AB) begin
            errors++; $display("FAIL pixel(64,0): got %h want 0ab", bus.rgb_out);
        end
        drive_px(0, 48, 12'h0AB);
        drive_px(1, 48, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'h0AB) begin
            errors++; $display("FAIL pixel(0,48): got %h want 0ab", bus.rgb_out);
        end
        rgb_fixed = 1'b1;
        run_frame(-1);
        rgb_fixed = 1'b0;
    endtask

    task automatic test_latency();
        int vl[5] = '{625, 626, 627, 0, 1};
        foreach (vl[i]) for (int h = 0; h < 1056; h++) drive_px(h, vl[i], 12'($urandom));
    endtask

    task automatic test_request();
        stage_x.push_back(100); stage_y.push_back(200);
        run_frame(300);
        checks++;
        if (bus.pos_ready !== 1'b1) begin
            errors++; $display("FAIL request applied: pos_ready got %b want 1", bus.pos_ready);
        end
        drive_px(100, 200, 12'h0AB);
        drive_px(99, 200, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(100,200): got %h want f00", bus.rgb_out);
        end
        drive_px(0, 200, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'h0AB) begin
            errors++; $display("FAIL pixel(99,200): got %h want 0ab", bus.rgb_out);
        end
        run_frame(-1);
    endtask

    task automatic test_clip();
        stage_x.push_back(780); stage_y.push_back(590);
        run_frame(0);
        drive_px(799, 590, 12'h0AB);
        drive_px(800, 590, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(799,590): got %h want f00", bus.rgb_out);
        end
        drive_px(801, 590, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'h000) begin
            errors++; $display("FAIL blank pixel(800,590): got %h want 000", bus.rgb_out);
        end
        drive_px(0, 0, 12'h0AB);
        drive_px(1, 0, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'h0AB) begin
            errors++; $display("FAIL no-wrap pixel(0,0): got %h want 0ab", bus.rgb_out);
        end
        run_frame(-1);
    endtask

    task automatic test_hold();
        stage_x.push_back(50);  stage_y.push_back(37);
        stage_x.push_back(770); stage_y.push_back(199);
        run_frame(300);
        checks++;
        if (bus.pos_ready !== 1'b0) begin
            errors++; $display("FAIL held second request: pos_ready got %b want 0", bus.pos_ready);
        end
        run_frame(-1);
        checks++;
        if (bus.pos_ready !== 1'b1) begin
            errors++; $display("FAIL second request applied: pos_ready got %b want 1",
                               bus.pos_ready);
        end
        run_frame(-1);
    endtask

    task automatic test_reset_pending();
        req_x.push_back(100); req_y.push_back(200);
        drive_px(5, 300, 12'($urandom));
        checks++;
        if (bus.pos_ready !== 1'b0) begin
            errors++; $display("FAIL pending before reset: pos_ready got %b want 0",
                               bus.pos_ready);
        end
        apply_reset();
        run_frame(-1);
        run_frame(-1);
    endtask

    task automatic test_border();
        apply_reset();
        drive_px(1, 1, 12'h0AB);
        drive_px(2, 1, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(1,1): got %h want f00", bus.rgb_out);
        end
        drive_px(2, 2, 12'h0AB);
        drive_px(3, 2, 12'h0AB);
        checks++;
`ifdef DRAW_RECT_BORDER_EN
        if (bus.rgb_out !== 12'h0AB) begin
            errors++; $display("FAIL pixel(2,2): got %h want 0ab", bus.rgb_out);
        end
`else
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(2,2): got %h want f00", bus.rgb_out);
        end
`endif
        drive_px(63, 47, 12'h0AB);
        drive_px(64, 47, 12'h0AB);
        checks++;
        if (bus.rgb_out !== 12'hF00) begin
            errors++; $display("FAIL pixel(63,47): got %h want f00", bus.rgb_out);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_request();
        test_clip();
        test_hold();
        test_reset_pending();
        test_border();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
